seaccow_internal_core: RTL and testbench

//   Inline packet monitor on an Avalon-ST stream. Forwards the input stream

---
 rtl/seaccow_internal_core.sv | 80 ++++++++
 tb/tb_seaccow_internal_core.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seaccow_internal_core.sv
// seaccow_internal_core: inline Avalon-ST packet monitor with 1-cycle pass-through,
// packet counting/length/XOR-signature tracking, 7-segment count display and status LEDs.
package seaccow_pkg;
    localparam int DATA_W = 32;
    localparam int EMPTY_W = 2;
    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic               valid;
    } avln_st;
endpackage

module seaccow_internal_core
    import seaccow_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic         sys_clk,
    input  logic         reset_n,
    input  avln_st       in,
    output avln_st       out,
    output logic [55:0]  hex_disp,
    output logic [8:0]   LEDG
);
    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic              in_pkt;
    logic [31:0]       pkt_count;
    logic [7:0]        err_count;
    logic [LEN_W-1:0]  cur_len, last_len, max_len, len_nxt;
    logic [DATA_W-1:0] cur_sig, last_sig, sig_nxt;
    logic              owned, err_inc;
    always_comb begin
        len_nxt = in.sop ? LEN_W'(1) : (&cur_len ? cur_len : cur_len + LEN_W'(1));
        sig_nxt = in.sop ? in.data : cur_sig ^ in.data;
        owned   = in.sop | in_pkt;
        err_inc = in.sop ? in_pkt : (!in_pkt && in.eop);
    end
    // Display and LEDs trail the packet state by one register stage.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            out       <= '0;
            in_pkt    <= 1'b0;
            pkt_count <= '0;
            err_count <= '0;
            cur_len   <= '0;
            last_len  <= '0;
            max_len   <= '0;
            cur_sig   <= '0;
            last_sig  <= '0;
            LEDG      <= '0;
            hex_disp  <= {8{7'h40}};
        end else begin
            out  <= in;
            LEDG <= {last_len[4:0], last_len > LEN_W'(375), err_count != 8'd0, pkt_count[0], in_pkt};
            for (int k = 0; k < 8; k++)
                hex_disp[7*k +: 7] <= SEG[pkt_count[4*k +: 4]];
            if (in.valid) begin
                if (owned) begin
                    cur_len <= len_nxt;
                    cur_sig <= sig_nxt;
                end
                in_pkt <= owned && !in.eop;
                if (err_inc && err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
                if (owned && in.eop) begin
                    pkt_count <= pkt_count + 32'd1;
                    last_len  <= len_nxt;
                    last_sig  <= sig_nxt;
                    if (len_nxt > max_len)
                        max_len <= len_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_seaccow_internal_core.sv
// tb_seaccow_internal_core: randomized and directed stimulus checked every cycle against a
// packet-level reference model, plus literal expectations from hand-worked scenarios.
module tb_seaccow_internal_core;
    import seaccow_pkg::*;
    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    avln_st      din = '0;
    avln_st      dout;
    logic [55:0] hex_disp;
    logic [8:0]  LEDG;
    int total = 0;
    int bad = 0;

    seaccow_internal_core dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .in(din), .out(dout),
        .hex_disp(hex_disp), .LEDG(LEDG)
    );

    always #5 sys_clk = ~sys_clk;

    localparam logic [6:0] DIG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [55:0] hexof(input logic [31:0] v);
        logic [55:0] r;
        for (int i = 0; i < 8; i++) r[7*i +: 7] = DIG[(v >> (4*i)) & 32'hF];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the open packet is a queue of its words.
    logic [31:0] pkt_q[$];
    bit          m_inpkt, chk;
    logic [31:0] m_pkt, m_last_sig;
    int          m_err, m_last, m_max;
    avln_st      exp_out;
    logic [55:0] exp_hex;
    logic [8:0]  exp_led;

    function automatic logic [31:0] qxor();
        logic [31:0] x = 0;
        foreach (pkt_q[i]) x ^= pkt_q[i];
        return x;
    endfunction

    always @(posedge sys_clk) begin
        chk = 1'b1;
        if (!reset_n) begin
            pkt_q.delete();
            m_inpkt = 0; m_pkt = 0; m_err = 0; m_last = 0; m_max = 0; m_last_sig = 0;
            exp_out = '0; exp_hex = {8{7'h40}}; exp_led = '0;
        end else begin
            exp_out = din;
            exp_hex = hexof(m_pkt);
            exp_led = {5'(m_last), m_last > 375, m_err != 0, m_pkt[0], m_inpkt};
            if (din.valid) begin
                if (din.sop) begin
                    if (m_inpkt && m_err < 255) m_err++;
                    pkt_q.delete();
                    pkt_q.push_back(din.data);
                    m_inpkt = 1;
                end else if (m_inpkt) pkt_q.push_back(din.data);
                else if (din.eop && m_err < 255) m_err++;
                if (din.eop && m_inpkt) begin
                    m_pkt = m_pkt + 1;
                    m_last = pkt_q.size() > 65535 ? 65535 : pkt_q.size();
                    m_last_sig = qxor();
                    if (m_last > m_max) m_max = m_last;
                    m_inpkt = 0;
                    pkt_q.delete();
                end
            end
        end
    end

    always @(negedge sys_clk) if (chk) begin
        check("out", 64'(dout), 64'(exp_out));
        check("hex_disp", 64'(hex_disp), 64'(exp_hex));
        check("LEDG", 64'(LEDG), 64'(exp_led));
        check("pkt_count", 64'(dut.pkt_count), 64'(m_pkt));
        check("err_count", 64'(dut.err_count), 64'(m_err));
        check("last_len", 64'(dut.last_len), 64'(m_last));
        check("last_sig", 64'(dut.last_sig), 64'(m_last_sig));
        check("max_len", 64'(dut.max_len), 64'(m_max));
    end

    task automatic beat(input logic v, input logic s, input logic e, input logic [31:0] d,
                        input logic [1:0] em = 2'd0);
        din.valid = v; din.sop = s; din.eop = e; din.data = d; din.empty = em;
        @(posedge sys_clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        beat(0, 0, 0, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge sys_clk);
        #1 reset_n = 1'b1;
        repeat (10) beat(1, 0, 0, 0);
        check("idle_pkt", 64'(dut.pkt_count), 64'd0);
        check("idle_err", 64'(dut.err_count), 64'd0);
        check("idle_hex", 64'(hex_disp), 64'({8{7'h40}}));
        beat(1, 1, 0, 1); beat(1, 0, 0, 2); beat(1, 0, 0, 4); beat(1, 0, 1, 8, 2'd3);
        beat(0, 0, 0, 0); beat(0, 0, 0, 0);
        check("p4_pkt", 64'(dut.pkt_count), 64'd1);
        check("p4_len", 64'(dut.last_len), 64'd4);
        check("p4_sig", 64'(dut.last_sig), 64'h0F);
        check("p4_led_len", 64'(LEDG[8:4]), 64'd4);
        check("p4_digit0", 64'(hex_disp[6:0]), 64'h79);
        beat(1, 1, 1, 32'hDEADBEEF);
        check("p1_out", 64'(dout.data), 64'hDEADBEEF);
        check("p1_len", 64'(dut.last_len), 64'd1);
        check("p1_sig", 64'(dut.last_sig), 64'hDEADBEEF);
        beat(1, 1, 0, 5); beat(1, 0, 0, 6); beat(1, 1, 0, 7); beat(1, 0, 1, 9);
        beat(0, 0, 0, 0);
        check("abandon_err", 64'(dut.err_count), 64'd1);
        check("abandon_pkt", 64'(dut.pkt_count), 64'd3);
        check("abandon_len", 64'(dut.last_len), 64'd2);
        check("abandon_sig", 64'(dut.last_sig), 64'd14);
        check("abandon_led2", 64'(LEDG[2]), 64'd1);
        beat(1, 0, 1, 3);
        check("stray_err", 64'(dut.err_count), 64'd2);
        check("stray_pkt", 64'(dut.pkt_count), 64'd3);
        do_reset();
        for (int i = 0; i < 17; i++) beat(1, 1, 1, i);
        beat(0, 0, 0, 0); beat(0, 0, 0, 0);
        check("p17_digits", 64'(hex_disp[13:0]), 64'({7'h79, 7'h79}));
        check("p17_led1", 64'(LEDG[1]), 64'd1);
        beat(1, 1, 0, 1); beat(1, 0, 0, 2);
        do_reset();
        beat(1, 0, 1, 4);
        check("midrst_pkt", 64'(dut.pkt_count), 64'd0);
        check("midrst_err", 64'(dut.err_count), 64'd1);
        beat(1, 1, 0, 0);
        for (int i = 0; i < 399; i++) beat(1, 0, 0, $urandom);
        beat(1, 0, 1, 0);
        beat(0, 0, 0, 0);
        check("jumbo_len", 64'(dut.last_len), 64'd401);
        check("jumbo_led3", 64'(LEDG[3]), 64'd1);
        check("jumbo_led_len", 64'(LEDG[8:4]), 64'd17);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499) == 0) do_reset();
            else beat($urandom_range(9) < 8, $urandom_range(6) == 0, $urandom_range(5) == 0,
                      $urandom, 2'($urandom_range(3)));
        end
        beat(0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
